mux_arb_rr: RTL and testbench
=============================

MUX_ARB_RR -- requirements
Module: mux_arb_rr

Interface
REQ-001 The module SHALL have parameter WIDTH, default 5, meaning the data word width in bits (register-address width).
REQ-002 The module SHALL have parameter CHANNELS, default 4, meaning the number of input channels (≥1).
REQ-003 The module SHALL have parameter MODE, default 0, meaning arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The module SHALL have port in_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The module SHALL have port in_valid, input, CHANNELS bits: per-channel valid.
REQ-008 The module SHALL have port in_ready, output, CHANNELS bits: per-channel accept; at most one bit high per cycle.
REQ-009 The module SHALL have port out_data, output, WIDTH bits: registered selected word.
REQ-010 The module SHALL have port out_chan, output, max(1,clog2(CHANNELS)) bits: index of the channel that supplied out_data.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data/out_chan hold a word.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts the word when out_valid & out_ready.

Function
REQ-013 A transfer on channel i SHALL occur when in_valid[i] & in_ready[i] are both high at a rising edge.
REQ-014 load_en SHALL equal (!out_valid | out_ready); in_ready SHALL be zero whenever load_en is low.
REQ-015 When load_en is high, in_ready SHALL be the one-hot grant over in_valid; it SHALL be all-zero when in_valid is all-zero.
REQ-016 in_ready SHALL never depend on in_data; it MAY depend combinationally on in_valid and out_ready.
REQ-017 On a transfer, out_data, out_chan and out_valid=1 SHALL be registered on the same edge; latency is exactly 1 cycle.
REQ-018 While out_valid=1 and out_ready=0, out_data and out_chan SHALL remain stable.
REQ-019 On a drain (out_valid & out_ready) with no transfer, out_valid SHALL go to 0; out_data and out_chan SHALL hold their last value.
REQ-020 On a simultaneous drain and transfer, the new word SHALL replace the old one with out_valid held at 1, giving a sustained throughput of one word per cycle.
REQ-021 MODE=0: a pointer last_grant SHALL be kept; the search SHALL start at (last_grant+1) mod CHANNELS and wrap; last_grant SHALL update only on a transfer.
REQ-022 MODE=0: wrap-around SHALL be from channel CHANNELS-1 to channel 0; no channel with in_valid held high SHALL wait more than CHANNELS-1 transfers.
REQ-023 MODE=1: the lowest-index valid channel SHALL win; last_grant SHALL be unused.
REQ-024 CHANNELS=1: in_ready[0] SHALL equal load_en; out_chan SHALL be constant 0.
REQ-025 Inputs SHALL be sampled only when in_ready is high; in_valid falling without a grant SHALL have no effect.

Reset
REQ-026 When rst_n=0 at an edge: out_valid SHALL be 0, out_data SHALL be 0, out_chan SHALL be 0, and last_grant SHALL be CHANNELS-1, so channel 0 has first priority.
REQ-027 While rst_n=0, in_ready SHALL be all-zero.
REQ-028 A reset asserted while a word is held SHALL discard that word, and no transfer SHALL complete in that cycle.

Structure
REQ-029 Package mux_pkg SHALL hold the MODE encodings (MODE_RR=0, MODE_FIXED=1) and a clog2-based index-width function.
REQ-030 Arbitration SHALL be a sub-module rr_arbiter (parameters CHANNELS, MODE; ports req, ptr, grant, grant_idx), purely combinational; mux_arb_rr SHALL hold all state.
REQ-031 The data select SHALL be an AND-OR structure over the one-hot grant, with no priority-encoded if-chains on data.

Verification
REQ-032 Scenario: reset, then in_valid=4'b1111 with data 1,2,3,4 and out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles and out_valid continuously 1.
REQ-033 Scenario: MODE=1, in_valid=4'b1010 held -> every transfer goes to channel 1 and in_ready[3] never rises.
REQ-034 Scenario: word 5'h1F loaded, then out_ready=0 for 5 cycles -> out_data=1F stable, in_ready=0 throughout, and the next word is accepted on the cycle out_ready rises.
REQ-035 Scenario: single channel 2 valid with out_ready=1 -> out_chan=2 one cycle later; in_valid dropped -> out_valid=0 on the following cycle.
REQ-036 Scenario: rst_n=0 pulsed while out_valid=1 -> next cycle out_valid=0, out_data=0, and channel 0 is granted first afterwards.
REQ-037 Scenario: WIDTH=32, CHANNELS=3 random valid/ready for 10k cycles -> scoreboard order and data match, no grant starvation beyond 2 transfers, and in_ready is always one-hot or zero.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared encodings and helpers for the round-robin / fixed-priority mux.
package mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    // Width of a channel index; a single channel still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: one-hot grant plus its index over a request vector.
// MODE_RR searches upward from ptr+1 with wrap; MODE_FIXED lets the lowest index win.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR
) (
    input  logic [CHANNELS-1:0]            req,
    input  logic [idx_width(CHANNELS)-1:0] ptr,
    output logic [CHANNELS-1:0]            grant,
    output logic [idx_width(CHANNELS)-1:0] grant_idx
);

    localparam int          IW = idx_width(CHANNELS);
    localparam int unsigned N  = CHANNELS;

    int unsigned idx;
    logic        found;

    // Scan candidates in search order and take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (MODE == MODE_FIXED)
                idx = k;
            else
                idx = (32'(ptr) + 32'd1 + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// N-to-1 valid/ready multiplexer with a single registered output stage.
// Arbitration is delegated to rr_arbiter; all state lives here.
module mux_arb_rr
    import mux_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CHANNELS*WIDTH-1:0]       in_data,
    input  logic [CHANNELS-1:0]             in_valid,
    output logic [CHANNELS-1:0]             in_ready,
    output logic [WIDTH-1:0]                out_data,
    output logic [idx_width(CHANNELS)-1:0]  out_chan,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int          IW = idx_width(CHANNELS);
    localparam int unsigned N  = CHANNELS;

    logic                load_en;
    logic [CHANNELS-1:0] req;
    logic [IW-1:0]       last_grant;
    logic [IW-1:0]       grant_idx;
    logic [WIDTH-1:0]    sel_data;
    logic                xfer;

    assign load_en = !out_valid || out_ready;
    // Requests are masked during reset and while the output stage is blocked,
    // so the arbiter grant can drive in_ready directly.
    assign req     = (rst_n && load_en) ? in_valid : '0;
    assign xfer    = |in_ready;

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .MODE     (MODE)
    ) u_arb (
        .req       (req),
        .ptr       (last_grant),
        .grant     (in_ready),
        .grant_idx (grant_idx)
    );

    // AND-OR select of the granted channel's word.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++)
            sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{in_ready[i]}});
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_chan   <= '0;
            last_grant <= IW'(CHANNELS - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_chan  <= grant_idx;
            if (MODE == MODE_RR)
                last_grant <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Self-checking bench for mux_arb_rr: directed vector table, fixed-priority
// sequence and a randomized run against a behavioural reference model.
module tb_mux_arb_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // DUT A: defaults (WIDTH=5, CHANNELS=4, round-robin)
    logic        rst_a = 1'b0;
    logic [19:0] id_a  = '0;
    logic [3:0]  iv_a  = '0;
    logic [3:0]  ir_a;
    logic [4:0]  od_a;
    logic [1:0]  oc_a;
    logic        ov_a;
    logic        ordy_a = 1'b0;

    mux_arb_rr dut_a (
        .clk(clk), .rst_n(rst_a), .in_data(id_a), .in_valid(iv_a), .in_ready(ir_a),
        .out_data(od_a), .out_chan(oc_a), .out_valid(ov_a), .out_ready(ordy_a)
    );

    // DUT F: fixed priority
    logic        rst_f = 1'b0;
    logic [19:0] id_f  = '0;
    logic [3:0]  iv_f  = '0;
    logic [3:0]  ir_f;
    logic [4:0]  od_f;
    logic [1:0]  oc_f;
    logic        ov_f;
    logic        ordy_f = 1'b0;

    mux_arb_rr #(.WIDTH(5), .CHANNELS(4), .MODE(1)) dut_f (
        .clk(clk), .rst_n(rst_f), .in_data(id_f), .in_valid(iv_f), .in_ready(ir_f),
        .out_data(od_f), .out_chan(oc_f), .out_valid(ov_f), .out_ready(ordy_f)
    );

    // DUT R: WIDTH=32, CHANNELS=3, round-robin, random traffic
    logic        rst_r = 1'b0;
    logic [95:0] id_r  = '0;
    logic [2:0]  iv_r  = '0;
    logic [2:0]  ir_r;
    logic [31:0] od_r;
    logic [1:0]  oc_r;
    logic        ov_r;
    logic        ordy_r = 1'b0;

    mux_arb_rr #(.WIDTH(32), .CHANNELS(3), .MODE(0)) dut_r (
        .clk(clk), .rst_n(rst_r), .in_data(id_r), .in_valid(iv_r), .in_ready(ir_r),
        .out_data(od_r), .out_chan(oc_r), .out_valid(ov_r), .out_ready(ordy_r)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  iv;
        logic [19:0] id;
        logic        ordy;
        logic [3:0]  eir;
        logic        eov;
        logic [4:0]  eod;
        logic [1:0]  eoc;
    } vec_t;

    localparam logic [19:0] D   = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [19:0] D1F = {5'd4, 5'd3, 5'h1F, 5'd1};
    localparam logic [19:0] DA  = {5'd4, 5'h0A, 5'd2, 5'd1};

    vec_t tbl[19];

    typedef struct {
        logic [1:0]  chan;
        logic [31:0] data;
    } word_t;

    word_t sb[$];

    initial begin
        // ---------------- directed table on DUT A ----------------
        tbl[0]  = '{1'b0, 4'hF, D,   1'b1, 4'h0, 1'b0, 5'h00, 2'd0}; // reset
        tbl[1]  = '{1'b1, 4'hF, D,   1'b1, 4'h1, 1'b1, 5'h01, 2'd0}; // ch0 first
        tbl[2]  = '{1'b1, 4'hF, D,   1'b1, 4'h2, 1'b1, 5'h02, 2'd1};
        tbl[3]  = '{1'b1, 4'hF, D,   1'b1, 4'h4, 1'b1, 5'h03, 2'd2};
        tbl[4]  = '{1'b1, 4'hF, D,   1'b1, 4'h8, 1'b1, 5'h04, 2'd3};
        tbl[5]  = '{1'b1, 4'hF, D,   1'b1, 4'h1, 1'b1, 5'h01, 2'd0}; // wrap 3->0
        tbl[6]  = '{1'b1, 4'h2, D1F, 1'b1, 4'h2, 1'b1, 5'h1F, 2'd1}; // load 1F
        tbl[7]  = '{1'b1, 4'hF, D,   1'b0, 4'h0, 1'b1, 5'h1F, 2'd1}; // stall x5
        tbl[8]  = '{1'b1, 4'hF, D,   1'b0, 4'h0, 1'b1, 5'h1F, 2'd1};
        tbl[9]  = '{1'b1, 4'hF, D,   1'b0, 4'h0, 1'b1, 5'h1F, 2'd1};
        tbl[10] = '{1'b1, 4'hF, D,   1'b0, 4'h0, 1'b1, 5'h1F, 2'd1};
        tbl[11] = '{1'b1, 4'hF, D,   1'b0, 4'h0, 1'b1, 5'h1F, 2'd1};
        tbl[12] = '{1'b1, 4'hF, D,   1'b1, 4'h4, 1'b1, 5'h03, 2'd2}; // accept on ready
        tbl[13] = '{1'b1, 4'h4, DA,  1'b1, 4'h4, 1'b1, 5'h0A, 2'd2}; // single ch2
        tbl[14] = '{1'b1, 4'h0, D,   1'b1, 4'h0, 1'b0, 5'h0A, 2'd2}; // drain, hold data
        tbl[15] = '{1'b1, 4'h0, D,   1'b0, 4'h0, 1'b0, 5'h0A, 2'd2};
        tbl[16] = '{1'b1, 4'h2, D,   1'b0, 4'h2, 1'b1, 5'h02, 2'd1}; // empty stage loads
        tbl[17] = '{1'b0, 4'hF, D,   1'b0, 4'h0, 1'b0, 5'h00, 2'd0}; // reset while held
        tbl[18] = '{1'b1, 4'hF, D,   1'b1, 4'h1, 1'b1, 5'h01, 2'd0}; // ch0 first again

        for (int i = 0; i < 19; i++) begin
            rst_a  = tbl[i].rst;
            iv_a   = tbl[i].iv;
            id_a   = tbl[i].id;
            ordy_a = tbl[i].ordy;
            #1;
            check($sformatf("tbl%0d_in_ready", i), 64'(ir_a), 64'(tbl[i].eir));
            @(posedge clk); #1;
            check($sformatf("tbl%0d_out_valid", i), 64'(ov_a), 64'(tbl[i].eov));
            check($sformatf("tbl%0d_out_data", i), 64'(od_a), 64'(tbl[i].eod));
            check($sformatf("tbl%0d_out_chan", i), 64'(oc_a), 64'(tbl[i].eoc));
        end

        // ---------------- fixed priority on DUT F ----------------
        begin
            logic mov;
            logic [3:0] eir;
            rst_f = 1'b0; iv_f = 4'hA; id_f = D; ordy_f = 1'b1;
            #1;
            check("fix_rst_in_ready", 64'(ir_f), 64'h0);
            @(posedge clk); #1;
            check("fix_rst_out_valid", 64'(ov_f), 64'h0);
            mov = 1'b0;
            rst_f = 1'b1;
            for (int c = 0; c < 12; c++) begin
                ordy_f = (c < 4) ? 1'b1 : 1'($urandom_range(0, 1));
                #1;
                eir = (!mov || ordy_f) ? 4'h2 : 4'h0;
                check("fix_in_ready", 64'(ir_f), 64'(eir));
                @(posedge clk); #1;
                if (eir != 4'h0) mov = 1'b1;
                check("fix_out_valid", 64'(ov_f), 64'(mov));
                if (mov) begin
                    check("fix_out_chan", 64'(oc_f), 64'd1);
                    check("fix_out_data", 64'(od_f), 64'd2);
                end
            end
        end

        // ---------------- random run on DUT R vs reference model ----------------
        begin
            logic        m_ov;
            logic [31:0] m_od;
            logic [1:0]  m_oc;
            int          m_last;
            int          g;
            int          waits[3];
            logic        r_rst;
            logic [2:0]  exp_ir;
            word_t       w;

            m_ov = 1'b0; m_od = '0; m_oc = '0; m_last = 2;
            for (int i = 0; i < 3; i++) waits[i] = 0;
            rst_r = 1'b0; iv_r = '0; ordy_r = 1'b0;
            @(posedge clk); #1;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                r_rst  = ($urandom_range(0, 499) != 0);
                rst_r  = r_rst;
                iv_r   = 3'($urandom_range(0, 7));
                ordy_r = ($urandom_range(0, 3) != 0);
                id_r   = {$urandom, $urandom, $urandom};
                #1;
                // reference grant: first valid channel after the last grant, wrapping
                g = -1;
                if (r_rst && (!m_ov || ordy_r))
                    for (int k = 1; k <= 3; k++)
                        if (g < 0 && iv_r[(m_last + k) % 3]) g = (m_last + k) % 3;
                exp_ir = (g >= 0) ? 3'(1 << g) : 3'b000;
                check("rnd_in_ready", 64'(ir_r), 64'(exp_ir));
                check("rnd_onehot", 64'($countones(ir_r) <= 1), 64'd1);
                if (r_rst && m_ov && ordy_r) begin
                    if (sb.size() == 0) begin
                        check("rnd_sb_empty", 64'd1, 64'd0);
                    end else begin
                        w = sb.pop_front();
                        check("rnd_drain_chan", 64'(oc_r), 64'(w.chan));
                        check("rnd_drain_data", 64'(od_r), 64'(w.data));
                    end
                end
                for (int i = 0; i < 3; i++) begin
                    if (g == i || !iv_r[i] || !r_rst) begin
                        waits[i] = 0;
                    end else if (g >= 0) begin
                        waits[i]++;
                        check($sformatf("rnd_starve_ch%0d", i), 64'(waits[i] <= 2), 64'd1);
                    end
                end
                @(posedge clk); #1;
                if (!r_rst) begin
                    m_ov = 1'b0; m_od = '0; m_oc = '0; m_last = 2;
                    sb.delete();
                end else if (g >= 0) begin
                    m_ov = 1'b1;
                    m_od = id_r[g*32 +: 32];
                    m_oc = 2'(g);
                    m_last = g;
                    w.chan = 2'(g);
                    w.data = m_od;
                    sb.push_back(w);
                end else if (ordy_r) begin
                    m_ov = 1'b0;
                end
                check("rnd_out_valid", 64'(ov_r), 64'(m_ov));
                check("rnd_out_data", 64'(od_r), 64'(m_od));
                check("rnd_out_chan", 64'(oc_r), 64'(m_oc));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
